// File: rtl/eeg_oram_pkg.sv
// Shared defaults and arbiter state encoding for the ORAM requester arbiter.
package eeg_oram_pkg;
   localparam int ORAM_REQ_DW = 4;
   localparam int ORAM_ADD_AW = 12;
   localparam int ORAM_DAT_DW = 4;
   localparam int ORAM_TAG_DW = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;
endpackage

// File: rtl/eeg_oram_rr_arb.sv
// Round-robin arbiter with burst lock; one instance per shared ORAM channel.
//   state    | meaning
//   ARB_IDLE | pick first valid requester at/after ptr; blk_idle suppresses grant
//   ARB_LOCK | only gid is connected until its lst handshake
module eeg_oram_rr_arb #(
   parameter int N  = 4,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req_vld,
   input  logic [N-1:0]  req_lst,
   input  logic          oram_rdy,
   input  logic          blk_idle,
   output logic [N-1:0]  gnt_oh,
   output logic [AW-1:0] gnt_id,
   output logic          gnt_vld,
   output logic          first_hs
);
   import eeg_oram_pkg::*;

   arb_state_e    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] gid_q, gid_d;
   logic [AW-1:0] win;
   logic          found;
   logic          hs;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] id);
      return (int'(id) == N - 1) ? '0 : id + 1'b1;
   endfunction

   always_comb begin
      int j;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr_q) + i) % N;
         if (!found && req_vld[j]) begin
            found = 1'b1;
            win   = AW'(j);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gid_d    = gid_q;
      first_hs = 1'b0;
      if (state_q == ARB_LOCK) begin
         gnt_id  = gid_q;
         gnt_vld = req_vld[gid_q];
      end else begin
         gnt_id  = win;
         gnt_vld = found & ~blk_idle;
      end
      hs     = gnt_vld & oram_rdy;
      gnt_oh = gnt_vld ? (N'(1) << gnt_id) : '0;
      if (hs) begin
         if (state_q == ARB_IDLE) begin
            first_hs = 1'b1;
            if (req_lst[gnt_id]) begin
               ptr_d = nxt(gnt_id);
            end else begin
               state_d = ARB_LOCK;
               gid_d   = gnt_id;
            end
         end else if (req_lst[gid_q]) begin
            state_d = ARB_IDLE;
            ptr_d   = nxt(gid_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
      end
   end
endmodule

// File: rtl/eeg_oram_arb.sv
// Shares one ORAM port among requesters: write and read-address arbiters plus an
// in-order read-return tag FIFO. Optional EEG_ORAM_ARB_STAT_EN adds STAT_FULL_CNT.
module eeg_oram_arb #(
   parameter int ORAM_REQ_DW = eeg_oram_pkg::ORAM_REQ_DW,
   parameter int ORAM_ADD_AW = eeg_oram_pkg::ORAM_ADD_AW,
   parameter int ORAM_DAT_DW = eeg_oram_pkg::ORAM_DAT_DW,
   parameter int ORAM_TAG_DW = eeg_oram_pkg::ORAM_TAG_DW,
   parameter int ORAM_REQ_AW = $clog2(ORAM_REQ_DW)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [ORAM_REQ_DW-1:0]             REQ_MTOO_DAT_VLD,
   input  logic [ORAM_REQ_DW-1:0]             REQ_MTOO_DAT_LST,
   output logic [ORAM_REQ_DW-1:0]             REQ_MTOO_DAT_RDY,
   input  logic [ORAM_REQ_DW*ORAM_ADD_AW-1:0] REQ_MTOO_DAT_ADD,
   input  logic [ORAM_REQ_DW*ORAM_DAT_DW-1:0] REQ_MTOO_DAT_DAT,
   input  logic [ORAM_REQ_DW-1:0]             REQ_MTOO_ADD_VLD,
   input  logic [ORAM_REQ_DW-1:0]             REQ_MTOO_ADD_LST,
   output logic [ORAM_REQ_DW-1:0]             REQ_MTOO_ADD_RDY,
   input  logic [ORAM_REQ_DW*ORAM_ADD_AW-1:0] REQ_MTOO_ADD_ADD,
   output logic [ORAM_REQ_DW-1:0]             REQ_OTOM_DAT_VLD,
   output logic [ORAM_REQ_DW-1:0]             REQ_OTOM_DAT_LST,
   input  logic [ORAM_REQ_DW-1:0]             REQ_OTOM_DAT_RDY,
   output logic [ORAM_REQ_DW*ORAM_DAT_DW-1:0] REQ_OTOM_DAT_DAT,
   output logic                               ORAM_MTOO_DAT_VLD,
   output logic                               ORAM_MTOO_DAT_LST,
   output logic [ORAM_ADD_AW-1:0]             ORAM_MTOO_DAT_ADD,
   output logic [ORAM_DAT_DW-1:0]             ORAM_MTOO_DAT_DAT,
   input  logic                               ORAM_MTOO_DAT_RDY,
   output logic                               ORAM_MTOO_ADD_VLD,
   output logic                               ORAM_MTOO_ADD_LST,
   output logic [ORAM_ADD_AW-1:0]             ORAM_MTOO_ADD_ADD,
   input  logic                               ORAM_MTOO_ADD_RDY,
   input  logic                               ORAM_OTOM_DAT_VLD,
   input  logic                               ORAM_OTOM_DAT_LST,
   input  logic [ORAM_DAT_DW-1:0]             ORAM_OTOM_DAT_DAT,
   output logic                               ORAM_OTOM_DAT_RDY
`ifdef EEG_ORAM_ARB_STAT_EN
   ,output logic [15:0]                       STAT_FULL_CNT
`endif
);
   import eeg_oram_pkg::*;

   localparam int TAG_PW = $clog2(ORAM_TAG_DW);

   logic [ORAM_REQ_DW-1:0] wr_oh, rd_oh;
   logic [ORAM_REQ_AW-1:0] wr_id, rd_id;
   logic                   wr_vld, rd_vld;
   logic                   wr_first_unused, rd_first;
   logic                   rd_blk;

   logic [ORAM_REQ_AW-1:0] mem_q [ORAM_TAG_DW];
   logic [ORAM_REQ_AW-1:0] mem_d [ORAM_TAG_DW];
   logic [TAG_PW:0]        wp_q, wp_d, rp_q, rp_d;
   logic                   full, empty, push, pop;
   logic [ORAM_REQ_AW-1:0] head;

   eeg_oram_rr_arb #(.N(ORAM_REQ_DW), .AW(ORAM_REQ_AW)) u_wr_arb (
      .clk      (clk),
      .rst      (rst),
      .req_vld  (REQ_MTOO_DAT_VLD),
      .req_lst  (REQ_MTOO_DAT_LST),
      .oram_rdy (ORAM_MTOO_DAT_RDY),
      .blk_idle (1'b0),
      .gnt_oh   (wr_oh),
      .gnt_id   (wr_id),
      .gnt_vld  (wr_vld),
      .first_hs (wr_first_unused)
   );

   eeg_oram_rr_arb #(.N(ORAM_REQ_DW), .AW(ORAM_REQ_AW)) u_rd_arb (
      .clk      (clk),
      .rst      (rst),
      .req_vld  (REQ_MTOO_ADD_VLD),
      .req_lst  (REQ_MTOO_ADD_LST),
      .oram_rdy (ORAM_MTOO_ADD_RDY),
      .blk_idle (rd_blk),
      .gnt_oh   (rd_oh),
      .gnt_id   (rd_id),
      .gnt_vld  (rd_vld),
      .first_hs (rd_first)
   );

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[TAG_PW] != rp_q[TAG_PW]) &&
                  (wp_q[TAG_PW-1:0] == rp_q[TAG_PW-1:0]);
   assign head  = mem_q[rp_q[TAG_PW-1:0]];
   assign pop   = ~empty & REQ_OTOM_DAT_RDY[head] & ORAM_OTOM_DAT_VLD & ORAM_OTOM_DAT_LST;
   // A same-cycle pop frees the slot, so a full FIFO only blocks when nothing retires.
   assign rd_blk = rst | (full & ~pop);
   assign push   = rd_first;

   always_comb begin
      ORAM_MTOO_DAT_VLD = wr_vld;
      ORAM_MTOO_DAT_LST = wr_vld & REQ_MTOO_DAT_LST[wr_id];
      ORAM_MTOO_DAT_ADD = REQ_MTOO_DAT_ADD[int'(wr_id)*ORAM_ADD_AW +: ORAM_ADD_AW];
      ORAM_MTOO_DAT_DAT = REQ_MTOO_DAT_DAT[int'(wr_id)*ORAM_DAT_DW +: ORAM_DAT_DW];
      REQ_MTOO_DAT_RDY  = wr_oh & {ORAM_REQ_DW{ORAM_MTOO_DAT_RDY}};

      ORAM_MTOO_ADD_VLD = rd_vld;
      ORAM_MTOO_ADD_LST = rd_vld & REQ_MTOO_ADD_LST[rd_id];
      ORAM_MTOO_ADD_ADD = REQ_MTOO_ADD_ADD[int'(rd_id)*ORAM_ADD_AW +: ORAM_ADD_AW];
      REQ_MTOO_ADD_RDY  = rd_oh & {ORAM_REQ_DW{ORAM_MTOO_ADD_RDY}};

      ORAM_OTOM_DAT_RDY = ~empty & REQ_OTOM_DAT_RDY[head];
      REQ_OTOM_DAT_VLD  = empty ? '0 : (ORAM_REQ_DW'(ORAM_OTOM_DAT_VLD) << head);
      REQ_OTOM_DAT_LST  = empty ? '0 : (ORAM_REQ_DW'(ORAM_OTOM_DAT_VLD & ORAM_OTOM_DAT_LST) << head);
      REQ_OTOM_DAT_DAT  = {ORAM_REQ_DW{ORAM_OTOM_DAT_DAT}};
   end

   always_comb begin
      mem_d = mem_q;
      wp_d  = push ? wp_q + 1'b1 : wp_q;
      rp_d  = pop  ? rp_q + 1'b1 : rp_q;
      if (push) mem_d[wp_q[TAG_PW-1:0]] = rd_id;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q <= '0;
         rp_q <= '0;
         for (int i = 0; i < ORAM_TAG_DW; i++) mem_q[i] <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         mem_q <= mem_d;
      end
   end

`ifdef EEG_ORAM_ARB_STAT_EN
   logic [15:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if (full && (|REQ_MTOO_ADD_VLD) && (stat_q != 16'hFFFF)) stat_d = stat_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stat_q <= '0;
      else     stat_q <= stat_d;
   end

   assign STAT_FULL_CNT = stat_q;
`endif
endmodule

// File: tb/tb_eeg_oram_arb.sv
// Directed bench for eeg_oram_arb: write round-robin, burst lock, tag FIFO order and reset.
module tb_eeg_oram_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  wr_vld, wr_lst, wr_rdy;
   logic [47:0] wr_add;
   logic [15:0] wr_dat;
   logic [3:0]  ad_vld, ad_lst, ad_rdy;
   logic [47:0] ad_add;
   logic [3:0]  rt_vld, rt_lst, rt_rdy;
   logic [15:0] rt_dat;
   logic        o_wr_vld, o_wr_lst, o_wr_rdy;
   logic [11:0] o_wr_add;
   logic [3:0]  o_wr_dat;
   logic        o_ad_vld, o_ad_lst, o_ad_rdy;
   logic [11:0] o_ad_add;
   logic        o_rt_vld, o_rt_lst, o_rt_rdy;
   logic [3:0]  o_rt_dat;
`ifdef EEG_ORAM_ARB_STAT_EN
   logic [15:0] stat_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   eeg_oram_arb dut (
      .clk               (clk),
      .rst               (rst),
      .REQ_MTOO_DAT_VLD  (wr_vld),
      .REQ_MTOO_DAT_LST  (wr_lst),
      .REQ_MTOO_DAT_RDY  (wr_rdy),
      .REQ_MTOO_DAT_ADD  (wr_add),
      .REQ_MTOO_DAT_DAT  (wr_dat),
      .REQ_MTOO_ADD_VLD  (ad_vld),
      .REQ_MTOO_ADD_LST  (ad_lst),
      .REQ_MTOO_ADD_RDY  (ad_rdy),
      .REQ_MTOO_ADD_ADD  (ad_add),
      .REQ_OTOM_DAT_VLD  (rt_vld),
      .REQ_OTOM_DAT_LST  (rt_lst),
      .REQ_OTOM_DAT_RDY  (rt_rdy),
      .REQ_OTOM_DAT_DAT  (rt_dat),
      .ORAM_MTOO_DAT_VLD (o_wr_vld),
      .ORAM_MTOO_DAT_LST (o_wr_lst),
      .ORAM_MTOO_DAT_ADD (o_wr_add),
      .ORAM_MTOO_DAT_DAT (o_wr_dat),
      .ORAM_MTOO_DAT_RDY (o_wr_rdy),
      .ORAM_MTOO_ADD_VLD (o_ad_vld),
      .ORAM_MTOO_ADD_LST (o_ad_lst),
      .ORAM_MTOO_ADD_ADD (o_ad_add),
      .ORAM_MTOO_ADD_RDY (o_ad_rdy),
      .ORAM_OTOM_DAT_VLD (o_rt_vld),
      .ORAM_OTOM_DAT_LST (o_rt_lst),
      .ORAM_OTOM_DAT_DAT (o_rt_dat),
      .ORAM_OTOM_DAT_RDY (o_rt_rdy)
`ifdef EEG_ORAM_ARB_STAT_EN
      ,.STAT_FULL_CNT    (stat_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_rr [5]    = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
   int         rd_ids [4]    = '{3, 0, 1, 2};
   int         drain_ids [4] = '{1, 2, 3, 1};

   initial begin
      rst = 1'b1;
      wr_vld = '0; wr_lst = '0; ad_vld = '0; ad_lst = '0; rt_rdy = '0;
      o_wr_rdy = 1'b0; o_ad_rdy = 1'b0;
      o_rt_vld = 1'b0; o_rt_lst = 1'b0; o_rt_dat = '0;
      for (int i = 0; i < 4; i++) begin
         wr_add[i*12 +: 12] = 12'hA00 + 12'(i);
         wr_dat[i*4 +: 4]   = 4'(i + 5);
         ad_add[i*12 +: 12] = 12'hB00 + 12'(i);
      end
      repeat (2) step();
      chk("rst_wr_vld",  32'(o_wr_vld), 32'd0);
      chk("rst_wr_rdy",  32'(wr_rdy),   32'd0);
      chk("rst_ret_rdy", 32'(o_rt_rdy), 32'd0);
      chk("rst_ret_vld", 32'(rt_vld),   32'd0);
      ad_vld = 4'hF; ad_lst = 4'hF; o_ad_rdy = 1'b1;
      #1;
      chk("rst_add_vld_held", 32'(o_ad_vld), 32'd0);
      chk("rst_add_rdy_held", 32'(ad_rdy),   32'd0);
      ad_vld = '0;
      step();
      rst = 1'b0;

      // single-beat writes from 0 and 2 alternate
      o_wr_rdy = 1'b1; wr_vld = 4'b0101; wr_lst = 4'hF;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("wr_rr_gnt", 32'(wr_rdy), 32'(exp_rr[k]));
         chk("wr_rr_add", 32'(o_wr_add), (exp_rr[k] == 4'b0001) ? 32'hA00 : 32'hA02);
         step();
      end
      wr_vld = '0;

      // 3-beat burst from 1 while 3 waits
      wr_vld = 4'b1010; wr_lst = 4'b1000;
      #1;
      chk("burst_b0_gnt", 32'(wr_rdy),   32'b0010);
      chk("burst_b0_lst", 32'(o_wr_lst), 32'd0);
      chk("burst_b0_add", 32'(o_wr_add), 32'hA01);
      step();
      #1;
      chk("burst_b1_gnt", 32'(wr_rdy), 32'b0010);
      step();
      wr_lst = 4'b1010;
      #1;
      chk("burst_b2_gnt", 32'(wr_rdy),   32'b0010);
      chk("burst_b2_lst", 32'(o_wr_lst), 32'd1);
      step();
      wr_vld = 4'b1000;
      #1;
      chk("burst_next_gnt", 32'(wr_rdy),   32'b1000);
      chk("burst_next_add", 32'(o_wr_add), 32'hA03);
      chk("burst_next_dat", 32'(o_wr_dat), 32'h8);
      step();
      wr_vld = '0;

      // four reads fill the tag FIFO
      o_ad_rdy = 1'b1; ad_lst = 4'hF; rt_rdy = '0;
      for (int k = 0; k < 4; k++) begin
         ad_vld = 4'(1 << rd_ids[k]);
         #1;
         chk("rd_push_rdy", 32'(ad_rdy),   32'(1 << rd_ids[k]));
         chk("rd_push_add", 32'(o_ad_add), 32'hB00 + 32'(rd_ids[k]));
         step();
      end
      ad_vld = 4'hF;
      #1;
      chk("full_add_rdy", 32'(ad_rdy),   32'd0);
      chk("full_add_vld", 32'(o_ad_vld), 32'd0);
      chk("full_ret_rdy", 32'(o_rt_rdy), 32'd0);
      step();
      ad_vld = '0;

      // head requester 3 stalls the return for 5 cycles
      o_rt_vld = 1'b1; o_rt_lst = 1'b1; o_rt_dat = 4'hA; rt_rdy = 4'b0111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_oram_rdy", 32'(o_rt_rdy), 32'd0);
         chk("stall_ret_vld",  32'(rt_vld),   32'b1000);
         step();
      end
      rt_rdy = 4'hF;
      #1;
      chk("ret3_oram_rdy", 32'(o_rt_rdy), 32'd1);
      chk("ret3_vld",      32'(rt_vld),   32'b1000);
      chk("ret3_dat",      32'(rt_dat),   32'hAAAA);
      step();
      o_rt_vld = 1'b0;
      ad_vld = 4'b1000;
      #1;
      chk("refill_rdy", 32'(ad_rdy), 32'b1000);
      step();

      // full: pop of head 0 and push of 1 in the same cycle
      ad_vld = 4'b0010; o_rt_vld = 1'b1; o_rt_lst = 1'b1;
      #1;
      chk("sim_ret_vld",  32'(rt_vld),   32'b0001);
      chk("sim_ret_rdy",  32'(o_rt_rdy), 32'd1);
      chk("sim_add_rdy",  32'(ad_rdy),   32'b0010);
      chk("sim_add_vld",  32'(o_ad_vld), 32'd1);
      step();
      o_rt_vld = 1'b0; ad_vld = 4'hF;
      #1;
      chk("sim_still_full", 32'(ad_rdy), 32'd0);
`ifdef EEG_ORAM_ARB_STAT_EN
      chk("stat_full_cnt", 32'(stat_cnt), 32'd2);
`endif
      step();
      ad_vld = '0;

      // drain; first beat to head 1 is not last, so no pop
      o_rt_vld = 1'b1; o_rt_lst = 1'b0;
      #1;
      chk("mb_ret_vld", 32'(rt_vld), 32'b0010);
      chk("mb_ret_lst", 32'(rt_lst), 32'd0);
      step();
      o_rt_lst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("drain_vld", 32'(rt_vld), 32'(1 << drain_ids[k]));
         chk("drain_lst", 32'(rt_lst), 32'(1 << drain_ids[k]));
         step();
      end
      #1;
      chk("empty_ret_rdy", 32'(o_rt_rdy), 32'd0);
      chk("empty_ret_vld", 32'(rt_vld),   32'd0);
      o_rt_vld = 1'b0;

      // burst beats after its first beat filled the FIFO are still accepted
      ad_vld = 4'b0100; ad_lst = 4'hF;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("pre_burst_rdy", 32'(ad_rdy), 32'b0100);
         step();
      end
      ad_lst = 4'h0;
      #1;
      chk("rd_burst_b0", 32'(ad_rdy), 32'b0100);
      step();
      ad_lst = 4'hF;
      #1;
      chk("rd_lock_full_rdy", 32'(ad_rdy),   32'b0100);
      chk("rd_lock_full_vld", 32'(o_ad_vld), 32'd1);
      step();
      #1;
      chk("rd_after_burst_full", 32'(ad_rdy), 32'd0);
      ad_vld = '0;

      // reset while the write arbiter is locked on requester 3 with ptr=3
      wr_vld = 4'b0100; wr_lst = 4'hF;
      #1;
      chk("pre_lock_gnt", 32'(wr_rdy), 32'b0100);
      step();
      wr_vld = 4'b1000; wr_lst = 4'h0;
      #1;
      chk("lock_gnt", 32'(wr_rdy), 32'b1000);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      wr_vld = 4'b1010; wr_lst = 4'hF;
      o_rt_vld = 1'b1; o_rt_lst = 1'b1; rt_rdy = 4'hF;
      ad_vld = 4'hF; ad_lst = 4'hF;
      #1;
      chk("post_rst_wr_gnt",  32'(wr_rdy),   32'b0010);
      chk("post_rst_ret_rdy", 32'(o_rt_rdy), 32'd0);
      chk("post_rst_ret_vld", 32'(rt_vld),   32'd0);
      chk("post_rst_rd_gnt",  32'(ad_rdy),   32'b0001);
`ifdef EEG_ORAM_ARB_STAT_EN
      chk("post_rst_stat", 32'(stat_cnt), 32'd0);
`endif
      step();
      wr_vld = '0; ad_vld = '0; o_rt_vld = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
